// File: rtl/reg_serial_reader.sv
// reg_serial_reader: captures a parallel word on a read strobe and drains it
//   as a bit-serial stream, one bit per clock.
// Latency: ren sampled at edge N puts the first bit on sout in the cycle after
//   edge N. The last data bit is in cycle N+WIDTH. done pulses in cycle
//   N+WIDTH+1, or N+WIDTH+2 when the parity bit is appended.
// Backpressure: none downstream. ren is honoured only while ready=1. A strobe
//   that arrives while busy is dropped; it is not queued and no error is flagged.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; overrides every other input
//   ren        read/load strobe, sampled only while ready=1
//   IN         parallel word to be read out
//   ready      1 = idle, a strobe is accepted at the next edge
//   sout       serial data bit
//   sout_valid 1 = sout carries a valid bit this cycle
//   done       one-cycle pulse in the first idle cycle after a stream
//   busy_cnt   number of bits already shifted out for the current word
//
// Optional build macro REG_SERIAL_READER_PARITY_EN appends an even-parity bit
// to every word. The parity bit is the XOR of all captured bits. It is sent in
// a PAR state that follows the last data bit.

module reg_serial_reader #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ren,
  input  logic [WIDTH-1:0]             IN,
  output logic                         ready,
  output logic                         sout,
  output logic                         sout_valid,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   busy_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  // Bit position that is presented on sout. The register always shifts
  // toward this end, so sout is simply one bit of the shift register.
  localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("reg_serial_reader: WIDTH must be in 2..32");
  end

`ifdef REG_SERIAL_READER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;

`ifdef REG_SERIAL_READER_PARITY_EN
  logic             parity;
`endif

  // The register moves one place toward the output end and fills with zero.
  // In IDLE the register is therefore all zero after a completed stream, and
  // sout reads 0 there without any extra gating.
  always_comb begin
    shreg_shifted = '0;
    if (MSB_FIRST != 0) begin
      shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign sout = shreg[OUT_IDX];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      busy_cnt   <= '0;
      ready      <= 1'b1;
      sout_valid <= 1'b0;
      done       <= 1'b0;
`ifdef REG_SERIAL_READER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      // done is a pulse. It is set only on the edge that returns to IDLE.
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (ren) begin
            state      <= SHIFT;
            shreg      <= IN;
            busy_cnt   <= '0;
            ready      <= 1'b0;
            sout_valid <= 1'b1;
`ifdef REG_SERIAL_READER_PARITY_EN
            parity     <= ^IN;
`endif
          end
        end

        SHIFT: begin
          if (busy_cnt == LAST_CNT) begin
`ifdef REG_SERIAL_READER_PARITY_EN
            // The last data bit leaves the register. The parity bit takes its
            // place at the output end, so sout carries it during PAR.
            state           <= PAR;
            shreg           <= shreg_shifted;
            shreg[OUT_IDX]  <= parity;
            busy_cnt        <= busy_cnt + CW'(1);
`else
            state      <= IDLE;
            shreg      <= shreg_shifted;
            busy_cnt   <= '0;
            ready      <= 1'b1;
            sout_valid <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            shreg    <= shreg_shifted;
            busy_cnt <= busy_cnt + CW'(1);
          end
        end

`ifdef REG_SERIAL_READER_PARITY_EN
        PAR: begin
          // This shift pushes the parity bit out. The register is left all zero.
          state      <= IDLE;
          shreg      <= shreg_shifted;
          busy_cnt   <= '0;
          ready      <= 1'b1;
          sout_valid <= 1'b0;
          done       <= 1'b1;
        end
`endif

        default: begin
          state      <= IDLE;
          shreg      <= '0;
          busy_cnt   <= '0;
          ready      <= 1'b1;
          sout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
